// File: rtl/data_mem_responder.sv
// Data memory responder: valid/ready request channel, programmable wait cycles,
// registered response channel, with RV32I byte/half/word load extension and access checking.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             op_write;
    logic [31:0]      op_addr;
    logic [2:0]       op_funct3;
    logic [31:0]      op_wdata;
    logic [IDX_W-1:0] op_idx;
    logic             op_err;
    logic [31:0]      rd_word, rd_shift, ld_data;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             commit, mem_we;

    // With LATENCY=0 the commit happens in the accept cycle, so operands come straight from the request.
    always_comb begin
        op_write  = (state_q == ST_IDLE) ? req_write  : write_q;
        op_addr   = (state_q == ST_IDLE) ? req_addr   : addr_q;
        op_funct3 = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
        op_wdata  = (state_q == ST_IDLE) ? req_wdata  : wdata_q;
        op_idx    = op_addr[IDX_W+1:2];

        op_err = 1'b0;
        if (op_write ? (op_funct3 > 3'd2) : (op_funct3 == 3'd3 || op_funct3[2:1] == 2'b11))
            op_err = 1'b1;
        if ((op_funct3[1:0] == 2'd1 && op_addr[0]) || (op_funct3[1:0] == 2'd2 && op_addr[1:0] != 2'b00))
            op_err = 1'b1;
        if ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS))
            op_err = 1'b1;

        rd_word  = mem[op_idx];
        rd_shift = rd_word >> {op_addr[1:0], 3'b000};
        case (op_funct3)
            3'd0:    ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd2:    ld_data = rd_word;
            3'd4:    ld_data = {24'd0, rd_shift[7:0]};
            3'd5:    ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = '0;
        endcase

        case (op_funct3[1:0])
            2'd0: begin
                wr_be   = 4'b0001 << op_addr[1:0];
                wr_data = {4{op_wdata[7:0]}};
            end
            2'd1: begin
                wr_be   = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{op_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = op_wdata;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        commit       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    funct3_d    = req_funct3;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        commit = 1'b1;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) commit = 1'b1;
                else               cnt_d  = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = op_err;
            resp_rdata_d = (op_err || op_write) ? '0 : ld_data;
        end
        mem_we = commit && op_write && !op_err && reset;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[op_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one LATENCY=2 instance and one LATENCY=0 instance,
// selected by sel; expectations come from a byte-addressed reference memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        sel;

    logic        rdy_a, rv_a, err_a, rdy_b, rv_b, err_b;
    logic [31:0] rd_a, rd_b;
    logic        cur_ready, cur_rvalid, cur_err;
    logic [31:0] cur_rdata;
    logic        vld_a, vld_b;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mdl [2][1024];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign vld_a      = req_valid && !sel;
    assign vld_b      = req_valid && sel;
    assign cur_ready  = sel ? rdy_b : rdy_a;
    assign cur_rvalid = sel ? rv_b  : rv_a;
    assign cur_rdata  = sel ? rd_b  : rd_a;
    assign cur_err    = sel ? err_b : err_a;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .req_valid(vld_a), .req_ready(rdy_a),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(rv_a), .resp_ready(resp_ready), .resp_rdata(rd_a), .resp_err(err_a)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(vld_b), .req_ready(rdy_b),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(rv_b), .resp_ready(resp_ready), .resp_rdata(rd_b), .resp_err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference behaviour; stores update the model and produce a zero response.
    task automatic predict(input logic s, input logic wr, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] wd, output exp_t e);
        int unsigned nb;
        logic [31:0] v;
        nb = 1 << f3[1:0];
        e.err = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if ((addr % nb) != 0) e.err = 1'b1;
        if (addr >= 32'd1024) e.err = 1'b1;
        e.rdata = '0;
        if (!e.err) begin
            if (wr) begin
                for (int unsigned b = 0; b < nb; b++) mdl[s][addr + b] = wd[8*b +: 8];
            end else begin
                v = '0;
                for (int unsigned b = 0; b < nb; b++) v[8*b +: 8] = mdl[s][addr + b];
                if (!f3[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
                e.rdata = v;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("ready_valid_excl_a", {31'd0, rdy_a & rv_a}, 32'd0);
            check("ready_valid_excl_b", {31'd0, rdy_b & rv_b}, 32'd0);
        end
    end

    task automatic issue_and_accept(input logic wr, input logic [31:0] addr,
                                    input logic [2:0] f3, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_write = wr; req_addr = addr; req_funct3 = f3; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!cur_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept", {31'd0, cur_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~wr; req_addr = $urandom; req_funct3 = 3'($urandom); req_wdata = $urandom;
    endtask

    task automatic xact(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int unsigned hold);
        exp_t e, got;
        int lat;
        predict(sel, wr, addr, f3, wd, e);
        sb.push_back(e);
        resp_ready = (hold == 0);
        issue_and_accept(wr, addr, f3, wd);
        lat = 1;
        while (!cur_rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, sel ? 32'd1 : 32'd3);
        got = sb.pop_front();
        check("rdata", cur_rdata, got.rdata);
        check("err", {31'd0, cur_err}, {31'd0, got.err});
        check("ready_in_resp", {31'd0, cur_ready}, 32'd0);
        if (hold > 0) begin
            req_valid = 1'b1;
            for (int unsigned i = 0; i < hold; i++) begin
                @(negedge clk);
                check("bp_valid", {31'd0, cur_rvalid}, 32'd1);
                check("bp_rdata", cur_rdata, got.rdata);
                check("bp_err", {31'd0, cur_err}, {31'd0, got.err});
                check("bp_ready", {31'd0, cur_ready}, 32'd0);
            end
            req_valid = 1'b0;
            resp_ready = 1'b1;
        end
        @(negedge clk);
        check("post_ready", {31'd0, cur_ready}, 32'd1);
        check("post_valid", {31'd0, cur_rvalid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, cur_ready}, 32'd1);
        check({tag, "_valid"}, {31'd0, cur_rvalid}, 32'd0);
        check({tag, "_rdata"}, cur_rdata, 32'd0);
        check({tag, "_err"}, {31'd0, cur_err}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int n, c, na, nr;
        int acc_t[2], rsp_t[2];

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_funct3 = '0; req_wdata = '0; resp_ready = 1'b1; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_a");
        sel = 1'b1;
        check_reset_outputs("rst_b");
        sel = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle_a");

        xact(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0);
        xact(1'b0, 32'h10, 3'd2, 32'h0, 0);
        xact(1'b1, 32'h20, 3'd2, 32'h80FF7F01, 0);
        xact(1'b0, 32'h23, 3'd0, 32'h0, 0);
        xact(1'b0, 32'h23, 3'd4, 32'h0, 0);
        xact(1'b0, 32'h22, 3'd1, 32'h0, 0);
        xact(1'b0, 32'h20, 3'd5, 32'h0, 0);
        xact(1'b1, 32'h21, 3'd0, 32'h000000AA, 0);
        xact(1'b0, 32'h20, 3'd2, 32'h0, 0);
        xact(1'b1, 32'h26, 3'd1, 32'h1234BEEF, 0);
        xact(1'b0, 32'h24, 3'd2, 32'h0, 0);

        xact(1'b0, 32'h22, 3'd2, 32'h0, 0);
        xact(1'b1, 32'h21, 3'd1, 32'h5555, 0);
        xact(1'b0, 32'h20, 3'd2, 32'h0, 0);
        xact(1'b0, 32'd1024, 3'd2, 32'h0, 0);
        xact(1'b0, 32'h20, 3'd3, 32'h0, 0);
        xact(1'b0, 32'h20, 3'd6, 32'h0, 0);
        xact(1'b1, 32'h20, 3'd4, 32'hFFFFFFFF, 0);
        xact(1'b0, 32'h20, 3'd2, 32'h0, 0);

        xact(1'b0, 32'h10, 3'd2, 32'h0, 5);

        // Reset during WAIT must abort the store before it commits.
        xact(1'b1, 32'h30, 3'd2, 32'h0, 0);
        issue_and_accept(1'b1, 32'h30, 3'd2, 32'h12345678);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort_wait");
        reset = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(cur_rvalid);
        end
        check("abort_no_resp", n, 32'd0);
        xact(1'b0, 32'h30, 3'd2, 32'h0, 0);

        // Reset during RESP drops the response but keeps the committed store.
        resp_ready = 1'b0;
        issue_and_accept(1'b1, 32'h30, 3'd2, 32'h12345678);
        n = 0;
        while (!cur_rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("resp_before_reset", {31'd0, cur_rvalid}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("drop_resp");
        reset = 1'b1;
        resp_ready = 1'b1;
        predict(1'b0, 1'b1, 32'h30, 3'd2, 32'h12345678, e);
        xact(1'b0, 32'h30, 3'd2, 32'h0, 0);

        // LATENCY=0 instance: back-to-back SW then LW with resp_ready held high.
        sel = 1'b1;
        xact(1'b1, 32'h44, 3'd2, 32'h0BADF00D, 0);
        xact(1'b0, 32'h46, 3'd5, 32'h0, 0);
        predict(1'b1, 1'b1, 32'h40, 3'd2, 32'hCAFEF00D, e);
        sb.push_back(e);
        predict(1'b1, 1'b0, 32'h40, 3'd2, 32'h0, e);
        sb.push_back(e);
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h40; req_funct3 = 3'd2; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        na = 0; nr = 0; c = 0;
        acc_t = '{0, 0}; rsp_t = '{0, 0};
        while ((na < 2 || nr < 2) && c < 12) begin
            if (cur_ready && req_valid && na < 2) begin
                acc_t[na] = c;
                na++;
            end
            @(negedge clk);
            c++;
            if (na == 1) begin
                req_write = 1'b0; req_wdata = '0;
            end
            if (na == 2) req_valid = 1'b0;
            if (cur_rvalid && nr < 2) begin
                e = sb.pop_front();
                check("b2b_rdata", cur_rdata, e.rdata);
                check("b2b_err", {31'd0, cur_err}, {31'd0, e.err});
                rsp_t[nr] = c;
                nr++;
            end
        end
        req_valid = 1'b0;
        check("b2b_accepts", na, 32'd2);
        check("b2b_resps", nr, 32'd2);
        check("b2b_accept_gap", acc_t[1] - acc_t[0], 32'd2);
        check("b2b_resp0_lat", rsp_t[0] - acc_t[0], 32'd1);
        check("b2b_resp1_lat", rsp_t[1] - acc_t[1], 32'd1);
        check("sb_empty", sb.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
